seg7_card_decode: RTL and testbench
===================================

// Module: seg7_card_decode
// PURPOSE
//  Reverse path of the card display: samples a 7-segment HEX pattern and decodes
//  it back into the 4-bit card code. Used for display read-back and self-check.
//  A pattern must stay stable for STABLE_CYCLES samples before it is accepted.
//  Each change of accepted pattern is queued as an event {err, card}.
//  Events are handed out over a valid/ready interface.
// PARAMETERS
//  STABLE_CYCLES  3  consecutive identical samples required to accept; legal range >=2
//  DEPTH          4  event FIFO entries; power of 2, >=2
// PORTS
//  slow_clock  in   1  sole clock, all state updates on posedge
//  resetb      in   1  reset, synchronous, active-low
//  seg_in      in   7  HEX pattern, active-low, bit0=seg a .. bit6=seg g
//  valid_o     out  1  FIFO head holds an event
//  ready_i     in   1  consumer accepts head when valid_o&&ready_i
//  card_o      out  4  head card code: 0=blank, 1=A .. 10, 11=J, 12=Q, 13=K
//  err_o       out  1  head pattern is not a legal card/blank glyph
//  overflow_o  out  1  sticky: an event was dropped on a full FIFO
// BEHAVIOUR
//  - Decode table (seg_in -> card):
//    - 1111111->0 (blank), 0001000->1, 0100100->2, 0110000->3, 0011001->4.
//    - 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9.
//    - 1000000->10, 1100001->11, 0011000->12, 0001001->13.
//    - Any other pattern -> card 0 with err=1.
//  - Stage 1: seg_q <= seg_in every edge.
//  - Stability filter: registers cand and cnt. On each edge:
//    - seg_q!=cand: cand<=seg_q, cnt<=1.
//    - otherwise, while cnt<STABLE_CYCLES: cnt++ (saturates).
//  - Accept: when seg_q==cand, cnt==STABLE_CYCLES-1 and cand!=last.
//    - Push decode(cand) into the FIFO; last<=cand.
//    - Re-accepting the same pattern as last never creates an event.
//  - Latency: seg_in held from before edge 1 -> push at edge STABLE_CYCLES+1.
//    - valid_o is high after that edge if the FIFO was empty.
//  - Glitch rejection: a pattern held <STABLE_CYCLES samples makes no event.
//    - Example A->B(short)->A: no event.
//  - Any change of accepted pattern is an event, including a return to blank (card 0).
//  - FIFO is first-word-fall-through. card_o/err_o come from head storage,
//    forced to 0 when empty.
//  - Pop on valid_o&&ready_i.
//  - Push while full without a same-cycle pop: new event dropped, older entries
//    kept, overflow_o<=1 until reset.
//  - Push and pop in the same cycle while full: both occur, no drop.
//  - Push and pop in the same cycle while empty: push only; valid_o rises next cycle.
//  - Event order is preserved; occupancy stays in [0,DEPTH].
//  - Reset (resetb=0 at an edge), including mid-stream:
//    - seg_q=cand=last=7'h7F, cnt=STABLE_CYCLES, FIFO emptied.
//    - valid_o=0, card_o=0, err_o=0, overflow_o=0.
//    - A blank display after reset creates no event.
// STRUCTURE
//  - card_pkg: card_t (logic[3:0]); SEG_BLANK..SEG_KING 7-bit constants;
//    evt_t packed struct {err, card_t card}; function seg2card(seg)->evt_t.
//  - Sub-module card_evt_fifo (parameter DEPTH, width $bits(evt_t)):
//    - sync FIFO with push/pop/full/empty.
//    - Ptr/count width $clog2(DEPTH)+1.
//  - Top: sample reg, stability filter, last reg, overflow flag.
// TESTING (STABLE_CYCLES=3, DEPTH=4)
//  1. Reset, seg_in=7'h7F for 20 cycles -> valid_o=0, overflow_o=0 throughout.
//  2. seg_in=0001000 held, ready_i=1 -> valid_o=1 for exactly one cycle after
//     edge 4; card_o=1, err_o=0.
//  3. seg_in=0001001 for 2 cycles then 7'h7F -> no event ever.
//  4. seg_in=1010101 held -> one event card_o=0, err_o=1.
//  5. ready_i=0, five distinct cards 2,3,4,5,6, each held 5 cycles ->
//     - overflow_o=1, FIFO holds 2,3,4,5.
//     - Then ready_i=1 -> pops 2,3,4,5 in order, then valid_o=0.
//  6. Full FIFO, ready_i=1 on the push cycle -> no drop, overflow_o stays 0.
//     Then resetb=0 one edge -> valid_o=0, overflow_o=0, no stale event after release.

Source files
------------

// File: rtl/card_pkg.sv
// Shared types and glyph constants for the 7-segment card read-back path.
// Patterns are active-low, bit0 = segment a .. bit6 = segment g.
package card_pkg;

    typedef logic [3:0] card_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ACE   = 7'b0001000;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_10    = 7'b1000000;
    localparam logic [6:0] SEG_JACK  = 7'b1100001;
    localparam logic [6:0] SEG_QUEEN = 7'b0011000;
    localparam logic [6:0] SEG_KING  = 7'b0001001;

    typedef struct packed {
        logic  err;
        card_t card;
    } evt_t;

    // Unknown glyphs report card 0 with err set so they are distinguishable from blank.
    function automatic evt_t seg2card(input logic [6:0] seg);
        evt_t e;
        e.err  = 1'b0;
        e.card = 4'd0;
        case (seg)
            SEG_BLANK: e.card = 4'd0;
            SEG_ACE:   e.card = 4'd1;
            SEG_2:     e.card = 4'd2;
            SEG_3:     e.card = 4'd3;
            SEG_4:     e.card = 4'd4;
            SEG_5:     e.card = 4'd5;
            SEG_6:     e.card = 4'd6;
            SEG_7:     e.card = 4'd7;
            SEG_8:     e.card = 4'd8;
            SEG_9:     e.card = 4'd9;
            SEG_10:    e.card = 4'd10;
            SEG_JACK:  e.card = 4'd11;
            SEG_QUEEN: e.card = 4'd12;
            SEG_KING:  e.card = 4'd13;
            default:   e.err  = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/card_evt_fifo.sv
// First-word-fall-through event FIFO; head data reads as zero while empty.
// Handshake: a pop happens on a cycle where i_pop is high and the FIFO is not empty.
module card_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    // A push into a full FIFO is still taken when the same edge frees a slot.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/seg7_card_decode.sv
// Samples a HEX display pattern, debounces it and queues one {err, card}
// event per change of accepted pattern for a valid/ready consumer.
module seg7_card_decode
    import card_pkg::*;
#(
    parameter int STABLE_CYCLES = 3,
    parameter int DEPTH         = 4
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [6:0] seg_in,
    output logic       valid_o,
    input  logic       ready_i,
    output logic [3:0] card_o,
    output logic       err_o,
    output logic       overflow_o
);

    localparam int EW    = $bits(evt_t);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]       r_seg_q;
    logic [6:0]       r_cand;
    logic [6:0]       r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_overflow;

    logic             w_accept;
    logic             w_full;
    logic             w_empty;
    evt_t             w_evt;
    logic [EW-1:0]    w_head;

    // cnt hits STABLE_CYCLES-1 only once per run, so a held pattern is accepted once.
    assign w_accept = (r_seg_q == r_cand) && (r_cnt == CNT_HIT) && (r_cand != r_last);
    assign w_evt    = seg2card(r_cand);

    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            r_seg_q    <= SEG_BLANK;
            r_cand     <= SEG_BLANK;
            r_last     <= SEG_BLANK;
            r_cnt      <= CNT_MAX;
            r_overflow <= 1'b0;
        end else begin
            r_seg_q <= seg_in;
            if (r_seg_q != r_cand) begin
                r_cand <= r_seg_q;
                r_cnt  <= CNT_W'(1);
            end else if (r_cnt < CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) r_last <= r_cand;
            if (w_accept && w_full && !ready_i) r_overflow <= 1'b1;
        end
    end

    card_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .i_clk   (slow_clock),
        .i_rst_n (resetb),
        .i_push  (w_accept),
        .i_din   (w_evt),
        .i_pop   (ready_i),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign valid_o         = !w_empty;
    assign {err_o, card_o} = w_head;
    assign overflow_o      = r_overflow;

endmodule

// File: tb/tb_seg7_card_decode.sv
// Bench for seg7_card_decode: directed scenarios then randomized patterns,
// all outputs compared every cycle against a sample-run reference model.
module tb_seg7_card_decode;

    localparam int STABLE = 3;
    localparam int DEPTH  = 4;

    logic       slow_clock;
    logic       resetb;
    logic [6:0] seg_in;
    logic       valid_o;
    logic       ready_i;
    logic [3:0] card_o;
    logic       err_o;
    logic       overflow_o;

    int n_checks = 0;
    int n_errors = 0;

    // glyph[k] is the display pattern for card code k
    logic [6:0] glyph [14] = '{7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b1000000, 7'b1100001,
                               7'b0011000, 7'b0001001};

    // reference model state
    logic [4:0] exp_q [$];
    logic [6:0] m_prev;
    int         m_run;
    logic [6:0] m_last;
    logic       m_pend;
    logic [4:0] m_pend_evt;
    logic       m_ovf;

    seg7_card_decode #(
        .STABLE_CYCLES (STABLE),
        .DEPTH         (DEPTH)
    ) dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .seg_in     (seg_in),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .card_o     (card_o),
        .err_o      (err_o),
        .overflow_o (overflow_o)
    );

    // clock / reset
    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] decode(input logic [6:0] p);
        for (int k = 0; k < 14; k++)
            if (glyph[k] == p) return {1'b0, 4'(k)};
        return 5'b1_0000;
    endfunction

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        logic [4:0] head;
        @(posedge slow_clock);
        if (!resetb) begin
            exp_q.delete();
            m_prev = 7'h7F;
            m_run  = STABLE;
            m_last = 7'h7F;
            m_pend = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            if (exp_q.size() != 0 && ready_i) void'(exp_q.pop_front());
            if (m_pend) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(m_pend_evt);
                else m_ovf = 1'b1;
            end
            m_pend = 1'b0;
            if (seg_in == m_prev) begin
                if (m_run < STABLE) begin
                    m_run++;
                    if (m_run == STABLE && m_prev != m_last) begin
                        m_pend     = 1'b1;
                        m_pend_evt = decode(m_prev);
                    end
                    if (m_run == STABLE) m_last = m_prev;
                end
            end else begin
                m_prev = seg_in;
                m_run  = 1;
            end
        end
        #1;
        head = (exp_q.size() != 0) ? exp_q[0] : 5'd0;
        check_eq("valid", 8'(valid_o), 8'(exp_q.size() != 0));
        check_eq("card", 8'(card_o), 8'(head[3:0]));
        check_eq("err", 8'(err_o), 8'(head[4]));
        check_eq("overflow", 8'(overflow_o), 8'(m_ovf));
    endtask

    // driver tasks
    task automatic do_reset();
        resetb = 1'b0;
        seg_in = 7'h7F;
        step();
        resetb = 1'b1;
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = p;
        repeat (n) step();
    endtask

    initial begin
        resetb  = 1'b0;
        seg_in  = 7'h7F;
        ready_i = 1'b0;
        do_reset();

        // blank after reset makes no event
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq("t1_valid", 8'(valid_o), 8'd0);
            check_eq("t1_ovf", 8'(overflow_o), 8'd0);
        end

        // short king then blank: glitch rejected
        hold(glyph[13], 2);
        hold(7'h7F, 10);
        check_eq("t3_none", 8'(valid_o), 8'd0);

        // ace latency: event visible after edge 4, popped next edge
        ready_i = 1'b1;
        seg_in  = glyph[1];
        for (int e = 1; e <= 3; e++) begin
            step();
            check_eq("t2_idle", 8'(valid_o), 8'd0);
        end
        step();
        check_eq("t2_valid", 8'(valid_o), 8'd1);
        check_eq("t2_card", 8'(card_o), 8'd1);
        check_eq("t2_err", 8'(err_o), 8'd0);
        step();
        check_eq("t2_once", 8'(valid_o), 8'd0);

        // illegal glyph
        seg_in = 7'b1010101;
        repeat (4) step();
        check_eq("t4_err", 8'(err_o), 8'd1);
        check_eq("t4_card", 8'(card_o), 8'd0);
        hold(7'b1010101, 2);

        // overflow with a stalled consumer
        ready_i = 1'b0;
        for (int c = 2; c <= 6; c++) hold(glyph[c], 5);
        check_eq("t5_ovf", 8'(overflow_o), 8'd1);
        ready_i = 1'b1;
        for (int c = 2; c <= 5; c++) begin
            check_eq("t5_order", 8'(card_o), 8'(c));
            step();
        end
        check_eq("t5_drain", 8'(valid_o), 8'd0);

        // full FIFO with a same-cycle pop: nothing dropped
        ready_i = 1'b0;
        do_reset();
        for (int c = 7; c <= 10; c++) hold(glyph[c], 5);
        seg_in = glyph[11];
        repeat (3) step();
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        check_eq("t6_ovf", 8'(overflow_o), 8'd0);
        check_eq("t6_head", 8'(card_o), 8'd8);
        do_reset();
        check_eq("t6_rst_valid", 8'(valid_o), 8'd0);
        check_eq("t6_rst_ovf", 8'(overflow_o), 8'd0);
        hold(7'h7F, 8);
        check_eq("t6_stale", 8'(valid_o), 8'd0);

        // randomized patterns, hold lengths, back-pressure and resets
        for (int s = 0; s < 300; s++) begin
            int n;
            if ($urandom_range(0, 99) < 4) do_reset();
            if ($urandom_range(0, 9) < 7) seg_in = glyph[$urandom_range(0, 13)];
            else seg_in = 7'($urandom_range(0, 127));
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                ready_i = ($urandom_range(0, 3) != 0);
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
